jogo_memoria_param: RTL and testbench
=====================================

# jogo_memoria_param

Parametrised sequence-memory game controller, the next generation of the fixed 4-button experiment circuit. The block grows the target sequence by one pseudo-random element per round, up to `PROF` rounds. It can optionally replay the sequence on the LEDs before each round, and ends the game on a wrong press, on inactivity timeout, or when all rounds are complete. It sits between the board push-buttons/LEDs and the display-decoder debug logic.

## Interface
- `N_BOTOES`, 4: number of buttons and LEDs; legal values are 2, 4 and 8.
- `PROF`, 16: number of rounds needed to win; range 2..256.
- `TIMEOUT_CICLOS`, 5000: clock cycles allowed in ESPERA before timeout.
- `SHOW_CICLOS`, 500: cycles an element stays lit, and also the cycles of the dark gap after it, in display mode.
- `SEMENTE`, 8'h01: nonzero LFSR seed.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start or restart request.
- `modo` in 1: 0 = replay the sequence on the LEDs before each round; 1 = no replay.
- `botoes` in `N_BOTOES`: raw button levels, already synchronised.
- `acertou` out 1: game won.
- `errou` out 1: wrong press.
- `timeout` out 1: inactivity timeout.
- `pronto` out 1: game finished by any cause.
- `leds` out `N_BOTOES`: LED drive.
- `rodada` out `clog2(PROF)`: current round index, 0-based.
- `db_estado` out 4: FSM state code.

## Operation
- Moore FSM. All outputs are decoded from registered state, counters and memory only.
- Reset value of every output: 0. Reset loads state INICIAL (0).
- State codes: INICIAL 0, PREPARA 1, MOSTRA_LED 2, ESPERA 3, REGISTRA 4, COMPARA 5, NOVA_RODADA 6, MOSTRA_PAUSA 7, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT D.
- INICIAL:
  - `iniciar`=1 -> PREPARA.
- PREPARA:
  - load `lfsr` <= next(`SEMENTE`); `mem[0]` <= element; `rodada`=0; `j`=0.
  - latch `modo` for the whole game.
  - -> MOSTRA_LED if `modo`=0, else -> ESPERA.
- LFSR:
  - 8-bit; next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}.
  - element = one-hot of next[clog2(N_BOTOES)-1:0].
  - advances only in PREPARA and NOVA_RODADA.
- MOSTRA_LED:
  - `leds`=`mem[j]` for `SHOW_CICLOS` cycles, then -> MOSTRA_PAUSA.
- MOSTRA_PAUSA:
  - `leds`=0 for `SHOW_CICLOS` cycles.
  - if `j`<`rodada`: `j`++ and -> MOSTRA_LED.
  - else: `j`=0 and -> ESPERA.
- ESPERA:
  - `leds`=`botoes`; timeout counter increments.
  - A jogada is a cycle where `botoes`!=0 and the previous-cycle sample was 0. On a jogada: latch `botoes` into `jogada`, clear the timeout counter, -> REGISTRA.
  - timeout counter = `TIMEOUT_CICLOS`-1 with no jogada -> FIM_TIMEOUT.
  - Buttons held from the previous press produce no new jogada.
- REGISTRA -> COMPARA; one cycle, no other action.
- COMPARA, checks in this order:
  - `jogada`!=`mem[j]` -> FIM_ERRO. A multi-button press is always an error.
  - `j`<`rodada` -> `j`++, -> ESPERA.
  - `rodada`=`PROF`-1 -> FIM_ACERTO.
  - otherwise -> NOVA_RODADA.
- NOVA_RODADA:
  - `rodada`++; `mem[rodada+1]` <= new element; `j`=0.
  - -> MOSTRA_LED if `modo`=0, else -> ESPERA.
- End states:
  - `pronto`=1 in all three.
  - FIM_ACERTO: `acertou`=1, `leds` all ones.
  - FIM_ERRO: `errou`=1, `leds`=`mem[j]` (the expected element).
  - FIM_TIMEOUT: `timeout`=1, `leds`=0.
  - `iniciar`=1 -> PREPARA; the game restarts with the same seed.
- `iniciar` is ignored outside INICIAL and the end states.
- `reset` mid-game: INICIAL on the next edge. Memory contents are not cleared; they are harmless because PREPARA rewrites them.
- `rodada` holds its final value in the end states.

## Timing
- `iniciar` high at edge t -> PREPARA at t+1 -> first MOSTRA_LED or ESPERA at t+2.
- Jogada edge sampled at t -> REGISTRA t+1, COMPARA t+2.
- Terminal state, the next ESPERA, or NOVA_RODADA at t+3.
- After NOVA_RODADA, ESPERA at t+4 (`modo`=1).
- Each displayed element occupies exactly 2·`SHOW_CICLOS` cycles.
- `pronto`, `acertou`, `errou` and `timeout` rise in the same cycle as the terminal state.
- Timeout: ESPERA entered at t with no jogada -> FIM_TIMEOUT at t+`TIMEOUT_CICLOS`.

## Test plan
Bench settings: `N_BOTOES`=4, `PROF`=4, `TIMEOUT_CICLOS`=20, `SHOW_CICLOS`=3, `SEMENTE`=8'h01. The sequence is 0100, 0001, 0001, 0010.
- Reset, `modo`=1, `iniciar` pulse; press 0100; then 0100,0001; then 0100,0001,0001; then full sequence. Each press lasts 5 cycles with 5-cycle gaps. Required: `rodada` steps 0→3; `acertou`=`pronto`=1; `leds`=1111; `db_estado`=A.
- Same start; rounds 0-1 correct; round 2 pressed 0100,0001,0010. Required: FIM_ERRO at press edge +3; `errou`=1; `leds`=0001; `rodada`=2.
- Start, then no press. Required: `timeout`=`pronto`=1 exactly 20 cycles after ESPERA entry; `db_estado`=D.
- `modo`=0, round 1 reached. Required: `leds` shows 0100 for 3 cycles, 0 for 3, 0001 for 3, 0 for 3, then ESPERA.
- Button held 30 cycles during ESPERA. Required: exactly one jogada. Press of 0101. Required: FIM_ERRO.
- `reset` pulse during MOSTRA_LED. Required: next cycle all outputs 0, `db_estado`=0. Then `iniciar` in FIM_ERRO. Required: PREPARA and the sequence restarts at 0100.

Source files
------------

// File: rtl/jogo_memoria_if.sv
// Button/LED bus of the sequence-memory game.
//   master : board/testbench side, drives start, mode and buttons
//   slave  : game controller side, drives result flags, LEDs and debug
// Signals:
//   i_iniciar   start/restart request
//   i_modo      0 = replay sequence before each round, 1 = no replay
//   i_botoes    synchronised button levels
//   o_acertou   game won
//   o_errou     wrong press
//   o_timeout   inactivity timeout
//   o_pronto    game finished by any cause
//   o_leds      LED drive
//   o_rodada    current round, 0-based
//   o_db_estado FSM state code
interface jogo_memoria_if #(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16
);
    logic                      i_iniciar;
    logic                      i_modo;
    logic [N_BOTOES-1:0]       i_botoes;
    logic                      o_acertou;
    logic                      o_errou;
    logic                      o_timeout;
    logic                      o_pronto;
    logic [N_BOTOES-1:0]       o_leds;
    logic [$clog2(PROF)-1:0]   o_rodada;
    logic [3:0]                o_db_estado;

    modport master (
        output i_iniciar, i_modo, i_botoes,
        input  o_acertou, o_errou, o_timeout, o_pronto, o_leds, o_rodada, o_db_estado
    );

    modport slave (
        input  i_iniciar, i_modo, i_botoes,
        output o_acertou, o_errou, o_timeout, o_pronto, o_leds, o_rodada, o_db_estado
    );
endinterface

// File: rtl/jogo_memoria_param.sv
// Parametrised sequence-memory game controller (Moore FSM).
// Each round appends one pseudo-random one-hot element to the target
// sequence; the player must re-enter the whole sequence. Optional LED
// replay before each round, ends on wrong press, timeout or PROF rounds won.
// Ports:
//   i_clock  single clock, rising edge
//   i_reset  synchronous, active-high
//   bus      jogo_memoria_if slave modport (inputs, flags, LEDs, debug)
module jogo_memoria_param #(
    parameter int         N_BOTOES       = 4,
    parameter int         PROF           = 16,
    parameter int         TIMEOUT_CICLOS = 5000,
    parameter int         SHOW_CICLOS    = 500,
    parameter logic [7:0] SEMENTE        = 8'h01
) (
    input  logic           i_clock,
    input  logic           i_reset,
    jogo_memoria_if.slave  bus
);
    localparam int BW = $clog2(N_BOTOES);
    localparam int RW = $clog2(PROF);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int SW = $clog2(SHOW_CICLOS + 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
        MOSTRA_LED   = 4'h2,
        ESPERA       = 4'h3,
        REGISTRA     = 4'h4,
        COMPARA      = 4'h5,
        NOVA_RODADA  = 4'h6,
        MOSTRA_PAUSA = 4'h7,
        FIM_ACERTO   = 4'hA,
        FIM_TIMEOUT  = 4'hD,
        FIM_ERRO     = 4'hE
    } estado_t;

    estado_t             r_estado;
    logic [7:0]          r_lfsr;
    logic [N_BOTOES-1:0] r_mem [PROF];
    logic [RW-1:0]       r_rodada;
    logic [RW-1:0]       r_j;
    logic                r_modo;
    logic [N_BOTOES-1:0] r_jogada;
    logic [N_BOTOES-1:0] r_botoes_ant;
    logic [SW-1:0]       r_cnt_show;
    logic [TW-1:0]       r_cnt_to;

    logic [7:0]          w_lfsr_src;
    logic [7:0]          w_lfsr_nx;
    logic [N_BOTOES-1:0] w_elem;
    logic [RW-1:0]       w_idx_wr;
    logic                w_jogada;
    logic                w_show_fim;

    // PREPARA restarts from the seed so every game replays the same sequence.
    assign w_lfsr_src = (r_estado == PREPARA) ? SEMENTE : r_lfsr;
    assign w_lfsr_nx  = {w_lfsr_src[6:0], w_lfsr_src[7] ^ w_lfsr_src[5] ^ w_lfsr_src[4] ^ w_lfsr_src[3]};
    assign w_elem     = {{(N_BOTOES-1){1'b0}}, 1'b1} << w_lfsr_nx[BW-1:0];
    assign w_idx_wr   = (r_estado == PREPARA) ? '0 : r_rodada + RW'(1);
    // Rising edge of "any button": held buttons never count twice.
    assign w_jogada   = (bus.i_botoes != '0) && (r_botoes_ant == '0);
    assign w_show_fim = (r_cnt_show == SW'(SHOW_CICLOS - 1));

    // Sequence memory is never cleared; PREPARA rewrites entry 0 before use.
    always_ff @(posedge i_clock) begin
        if (!i_reset && (r_estado == PREPARA || r_estado == NOVA_RODADA))
            r_mem[w_idx_wr] <= w_elem;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado     <= INICIAL;
            r_lfsr       <= SEMENTE;
            r_rodada     <= '0;
            r_j          <= '0;
            r_modo       <= 1'b0;
            r_jogada     <= '0;
            r_botoes_ant <= '0;
            r_cnt_show   <= '0;
            r_cnt_to     <= '0;
        end else begin
            r_botoes_ant <= bus.i_botoes;
            // Counters run only in their own states and are zero on entry.
            r_cnt_show   <= '0;
            r_cnt_to     <= '0;
            case (r_estado)
                INICIAL: if (bus.i_iniciar) r_estado <= PREPARA;
                PREPARA: begin
                    r_lfsr   <= w_lfsr_nx;
                    r_rodada <= '0;
                    r_j      <= '0;
                    r_modo   <= bus.i_modo;
                    r_estado <= bus.i_modo ? ESPERA : MOSTRA_LED;
                end
                MOSTRA_LED: begin
                    if (w_show_fim) r_estado <= MOSTRA_PAUSA;
                    else            r_cnt_show <= r_cnt_show + SW'(1);
                end
                MOSTRA_PAUSA: begin
                    if (!w_show_fim) begin
                        r_cnt_show <= r_cnt_show + SW'(1);
                    end else if (r_j < r_rodada) begin
                        r_j      <= r_j + RW'(1);
                        r_estado <= MOSTRA_LED;
                    end else begin
                        r_j      <= '0;
                        r_estado <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (w_jogada) begin
                        r_jogada <= bus.i_botoes;
                        r_estado <= REGISTRA;
                    end else if (r_cnt_to == TW'(TIMEOUT_CICLOS - 1)) begin
                        r_estado <= FIM_TIMEOUT;
                    end else begin
                        r_cnt_to <= r_cnt_to + TW'(1);
                    end
                end
                REGISTRA: r_estado <= COMPARA;
                COMPARA: begin
                    if (r_jogada != r_mem[r_j]) begin
                        r_estado <= FIM_ERRO;
                    end else if (r_j < r_rodada) begin
                        r_j      <= r_j + RW'(1);
                        r_estado <= ESPERA;
                    end else if (r_rodada == RW'(PROF - 1)) begin
                        r_estado <= FIM_ACERTO;
                    end else begin
                        r_estado <= NOVA_RODADA;
                    end
                end
                NOVA_RODADA: begin
                    r_lfsr   <= w_lfsr_nx;
                    r_rodada <= r_rodada + RW'(1);
                    r_j      <= '0;
                    r_estado <= r_modo ? ESPERA : MOSTRA_LED;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                    if (bus.i_iniciar) r_estado <= PREPARA;
                default: r_estado <= INICIAL;
            endcase
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        bus.o_acertou   = 1'b0;
        bus.o_errou     = 1'b0;
        bus.o_timeout   = 1'b0;
        bus.o_pronto    = 1'b0;
        bus.o_leds      = '0;
        bus.o_rodada    = r_rodada;
        bus.o_db_estado = r_estado;
        case (r_estado)
            MOSTRA_LED: bus.o_leds = r_mem[r_j];
            ESPERA:     bus.o_leds = bus.i_botoes;
            FIM_ACERTO: begin
                bus.o_acertou = 1'b1;
                bus.o_pronto  = 1'b1;
                bus.o_leds    = '1;
            end
            FIM_ERRO: begin
                bus.o_errou  = 1'b1;
                bus.o_pronto = 1'b1;
                bus.o_leds   = r_mem[r_j];
            end
            FIM_TIMEOUT: begin
                bus.o_timeout = 1'b1;
                bus.o_pronto  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jogo_memoria_param.sv
module tb_jogo_memoria_param;
    localparam int NB = 4;
    localparam int PR = 4;
    localparam int TO = 20;
    localparam int SH = 3;

    localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_LED = 4'h2, S_ESP = 4'h3,
                           S_REG = 4'h4, S_NOVA = 4'h6, S_PAUSA = 4'h7,
                           S_ACE = 4'hA, S_TO = 4'hD, S_ERR = 4'hE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jogo_memoria_if #(.N_BOTOES(NB), .PROF(PR)) bus ();

    jogo_memoria_param #(
        .N_BOTOES(NB), .PROF(PR), .TIMEOUT_CICLOS(TO), .SHOW_CICLOS(SH), .SEMENTE(8'h01)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] botoes;
        int         ticks;
        logic [3:0] est;
        logic [1:0] rod;
        logic [3:0] leds;
    } vec_t;

    vec_t       vq[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] seq_ref [4] = '{4'h4, 4'h1, 4'h1, 4'h2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [3:0] est);
        case (est)
            S_ACE:   return 4'b1001;   // acertou, errou, timeout, pronto
            S_ERR:   return 4'b0101;
            S_TO:    return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_outs(input string tag, input logic [3:0] est, input logic [1:0] rod,
                              input logic [3:0] leds);
        check({tag, "_estado"}, int'(bus.o_db_estado), int'(est));
        check({tag, "_rodada"}, int'(bus.o_rodada), int'(rod));
        check({tag, "_leds"}, int'(bus.o_leds), int'(leds));
        check({tag, "_flags"}, int'({bus.o_acertou, bus.o_errou, bus.o_timeout, bus.o_pronto}),
              int'(flags_of(est)));
    endtask

    // One press: 1 edge to REGISTRA, +2 edges (t+3), +2 edges (t+5), then 5 released edges.
    task automatic push_press(input logic [3:0] x, input logic [1:0] r0,
                              input logic [3:0] s3, input logic [1:0] r3, input logic [3:0] l3,
                              input logic [3:0] s5, input logic [1:0] r5, input logic [3:0] l5,
                              input logic [3:0] lrel);
        vq.push_back('{x, 1, S_REG, r0, 4'h0});
        vq.push_back('{x, 2, s3, r3, l3});
        vq.push_back('{x, 2, s5, r5, l5});
        vq.push_back('{4'h0, 5, s5, r5, lrel});
    endtask

    task automatic run_table(input string nm);
        foreach (vq[i]) begin
            bus.i_botoes = vq[i].botoes;
            for (int k = 0; k < vq[i].ticks; k++) tick();
            check_outs($sformatf("%s_v%0d", nm, i), vq[i].est, vq[i].rod, vq[i].leds);
        end
        bus.i_botoes = 4'h0;
    endtask

    task automatic start(input logic m);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_modo    = m;
        bus.i_iniciar = 1'b1;
        tick();
        bus.i_iniciar = 1'b0;
        check("start_prepara", int'(bus.o_db_estado), int'(S_PREP));
        tick();
    endtask

    // Positioned just after the edge that entered MOSTRA_LED.
    task automatic check_show(input int nel, input logic [1:0] rod);
        for (int e = 0; e < nel; e++) begin
            for (int k = 0; k < SH; k++) begin
                check_outs($sformatf("show_e%0d_on%0d", e, k), S_LED, rod, seq_ref[e]);
                tick();
            end
            for (int k = 0; k < SH; k++) begin
                check_outs($sformatf("show_e%0d_off%0d", e, k), S_PAUSA, rod, 4'h0);
                tick();
            end
        end
        check_outs("show_end", S_ESP, rod, 4'h0);
    endtask

    task automatic fill_rounds01();
        push_press(4'h4, 2'd0, S_NOVA, 2'd0, 4'h0, S_ESP, 2'd1, 4'h4, 4'h0);
        push_press(4'h4, 2'd1, S_ESP, 2'd1, 4'h4, S_ESP, 2'd1, 4'h4, 4'h0);
        push_press(4'h1, 2'd1, S_NOVA, 2'd1, 4'h0, S_ESP, 2'd2, 4'h1, 4'h0);
    endtask

    initial begin
        bus.i_iniciar = 1'b0;
        bus.i_modo    = 1'b0;
        bus.i_botoes  = 4'h0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_outs("reset", S_INI, 2'd0, 4'h0);

        // Full win, modo=1
        start(1'b1);
        check_outs("win_espera0", S_ESP, 2'd0, 4'h0);
        vq.delete();
        fill_rounds01();
        push_press(4'h4, 2'd2, S_ESP, 2'd2, 4'h4, S_ESP, 2'd2, 4'h4, 4'h0);
        push_press(4'h1, 2'd2, S_ESP, 2'd2, 4'h1, S_ESP, 2'd2, 4'h1, 4'h0);
        push_press(4'h1, 2'd2, S_NOVA, 2'd2, 4'h0, S_ESP, 2'd3, 4'h1, 4'h0);
        push_press(4'h4, 2'd3, S_ESP, 2'd3, 4'h4, S_ESP, 2'd3, 4'h4, 4'h0);
        push_press(4'h1, 2'd3, S_ESP, 2'd3, 4'h1, S_ESP, 2'd3, 4'h1, 4'h0);
        push_press(4'h1, 2'd3, S_ESP, 2'd3, 4'h1, S_ESP, 2'd3, 4'h1, 4'h0);
        push_press(4'h2, 2'd3, S_ACE, 2'd3, 4'hF, S_ACE, 2'd3, 4'hF, 4'hF);
        run_table("win");

        // Wrong element in round 2
        start(1'b1);
        vq.delete();
        fill_rounds01();
        push_press(4'h4, 2'd2, S_ESP, 2'd2, 4'h4, S_ESP, 2'd2, 4'h4, 4'h0);
        push_press(4'h1, 2'd2, S_ESP, 2'd2, 4'h1, S_ESP, 2'd2, 4'h1, 4'h0);
        push_press(4'h2, 2'd2, S_ERR, 2'd2, 4'h1, S_ERR, 2'd2, 4'h1, 4'h1);
        run_table("err");

        // Timeout: exactly TO cycles after ESPERA entry
        start(1'b1);
        for (int k = 1; k < TO; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), int'(bus.o_db_estado), int'(S_ESP));
        end
        tick();
        check_outs("to_fim", S_TO, 2'd0, 4'h0);

        // Replay mode: round 0 then round 1 display
        start(1'b0);
        check_show(1, 2'd0);
        bus.i_botoes = 4'h4;
        tick();
        bus.i_botoes = 4'h0;
        tick();
        tick();
        check_outs("show_nova", S_NOVA, 2'd0, 4'h0);
        tick();
        check_show(2, 2'd1);

        // Held button: one jogada only, so timeout lands TO after re-entering ESPERA
        start(1'b1);
        bus.i_botoes = 4'h4;
        tick();
        check_outs("hold_reg", S_REG, 2'd0, 4'h0);
        for (int k = 2; k <= 4; k++) tick();
        check_outs("hold_esp", S_ESP, 2'd1, 4'h4);
        for (int k = 5; k < 4 + TO; k++) begin
            tick();
            check($sformatf("hold_t%0d", k), int'(bus.o_db_estado), int'(S_ESP));
        end
        tick();
        check_outs("hold_to", S_TO, 2'd1, 4'h0);
        for (int k = 4 + TO + 1; k < 30; k++) tick();
        check_outs("hold_end", S_TO, 2'd1, 4'h0);
        bus.i_botoes = 4'h0;
        tick();

        // Multi-button press after restart from FIM_TIMEOUT
        bus.i_iniciar = 1'b1;
        tick();
        bus.i_iniciar = 1'b0;
        check("multi_prepara", int'(bus.o_db_estado), int'(S_PREP));
        tick();
        bus.i_botoes = 4'h5;
        for (int k = 0; k < 3; k++) tick();
        check_outs("multi_err", S_ERR, 2'd0, 4'h4);
        bus.i_botoes = 4'h0;
        tick();

        // Reset during MOSTRA_LED
        start(1'b0);
        tick();
        check("rst_in_show", int'(bus.o_db_estado), int'(S_LED));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("rst_mid", S_INI, 2'd0, 4'h0);

        // Restart from FIM_ERRO replays from the seed
        start(1'b1);
        bus.i_botoes = 4'h1;
        for (int k = 0; k < 3; k++) tick();
        check_outs("rs_err", S_ERR, 2'd0, 4'h4);
        bus.i_botoes  = 4'h0;
        bus.i_modo    = 1'b0;
        bus.i_iniciar = 1'b1;
        tick();
        bus.i_iniciar = 1'b0;
        check_outs("rs_prepara", S_PREP, 2'd0, 4'h0);
        tick();
        check_outs("rs_show", S_LED, 2'd0, 4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
